// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int         BCD_DIGIT_W     = 4;
    localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;

endpackage : bin2bcd_pkg

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    // Correct one BCD digit ahead of the left shift
    always_comb begin
        if (din >= BCD_ADD3_THRESH) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule : bcd_add3

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one bit per clock.
// Optional leading-zero blanking mask built when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]             blank
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SCR_W = BCD_DIGIT_W * DIGITS;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digits_too_few
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]  blank_q, blank_d;

    logic [SCR_W-1:0]   corr_s;
    logic [SCR_W-1:0]   next_scr_s;
    logic [DIGITS-1:0]  mask_s;
    logic               last_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (corr_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The top scratch bit is dropped on the shift; DIGITS guarantees it is always 0
    assign next_scr_s = {corr_s[SCR_W-2:0], shreg_q[WIDTH-1]};
    assign last_s     = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef BIN2BCD_BLANK_EN
    // Blank a digit when it and every higher digit are zero; units always shown
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        mask_s     = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (next_scr_s[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
            mask_s[i]  = zero_above;
        end
        mask_s[0] = 1'b0;
    end
`else
    assign mask_s = '0;
`endif

    // Next-state, datapath and output-register logic
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        blank_d   = blank_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                scratch_d = next_scr_s;
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q + 1'b1;
                if (last_s) begin
                    bcd_d   = next_scr_s;
                    blank_d = mask_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            blank_q   <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign bcd   = bcd_q;
    assign blank = blank_q;

endmodule : bin2bcd_seq
